uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the baud-tick-driven transmitter.
- Oversamples the asynchronous serial line, detects and validates the start bit, samples each bit at mid-bit, and checks the stop bit.
- Presents each received byte on a valid/ready holding register to the downstream consumer, with framing and overrun flags.

Parameters:
- CLOCK_SPEED, 9600*16, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate in Hz.
- OVERSAMPLE, 16, ticks per bit period; even, >= 4.
- DATA_BITS, 8, payload bits per frame, LSB first.
- TPS, CLOCK_SPEED/(BAUD_RATE*OVERSAMPLE), clocks per sample tick; elaboration error if < 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx  in  1  asynchronous serial input; idle high.
- rx_data  out  DATA_BITS  received byte; stable while rx_valid = 1.
- rx_valid  out  1  byte available; held until accepted.
- rx_ready  in  1  consumer accepts when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  sticky: a frame completed while the holding register was full; cleared on the accept handshake.

Behaviour:
- Reset (reset = 0, asynchronous): rx_data = 0, rx_valid = 0, frame_err = 0, overrun = 0, state = IDLE. Synchronizer flops reset to 1. Tick counter and bit counter reset to 0.
- Synchronizer: rx passes through a 2-flop synchronizer; all logic uses the synchronized value rxs.
- Tick generator: counts 0..TPS-1 and pulses tick for one clk when the count reaches TPS-1. Held cleared in IDLE; released on start detect, so the first tick occurs TPS clocks after detection.
- State IDLE:
  - rxs == 0 → START, with sample count = 0.
- State START:
  - On each tick, increment sample count.
  - When sample count reaches OVERSAMPLE/2, sample rxs.
  - rxs == 0 → DATA, with sample count = 0 and bit index = 0.
  - rxs == 1 → glitch: return to IDLE with no output.
- State DATA:
  - Every OVERSAMPLE ticks, shift rxs into the shift register MSB end (frame is LSB first).
  - After DATA_BITS samples → STOP.
- State STOP:
  - Sample rxs after OVERSAMPLE ticks.
  - rxs == 1 → DONE for 1 clk.
  - rxs == 0 → pulse frame_err for 1 clk, discard the byte, → BREAK.
- State BREAK:
  - Wait for rxs == 1 → IDLE. A held-low line yields exactly one frame_err.
- DONE (load rule):
  - If rx_valid == 0, or the accept handshake occurs in this same cycle: load rx_data, set rx_valid = 1.
  - Otherwise: keep the old rx_data, set overrun = 1, drop the new byte.
  - DONE → IDLE.
  - The next frame may start in the clock after DONE.
- Accept handshake (rx_valid && rx_ready):
  - Clears rx_valid next clock unless reloaded by DONE in the same cycle.
  - Clears overrun.
- rx_ready while rx_valid = 0: ignored.
- Latency, with TPS = 1 and OVERSAMPLE = 16: rx_valid rises 2 + 1 + (8 + 16*(DATA_BITS+1)) + 1 clocks after the rx falling edge, i.e. 156 clocks for DATA_BITS = 8. Implementation must match this exactly.
- Mid-frame reset: abort immediately to reset values; the partial frame is lost.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - State PARITY sits between DATA and STOP and samples one bit at mid-bit.
  - Even parity is checked over the data bits.
  - Adds port parity_err (out, 1): one-cycle pulse in DONE on mismatch.
  - The byte is still loaded on parity mismatch.
  - Latency grows by OVERSAMPLE ticks.
- Undefined: no PARITY state and no parity_err port.

Decomposition:
- Package uart_pkg:
  - state enum rx_state_t (IDLE, START, DATA, PARITY, STOP, DONE, BREAK).
  - default constants DEFAULT_OVERSAMPLE = 16 and DEFAULT_DATA_BITS = 8.
  - function calc_tps(clock, baud, os).
- One sub-module: uart_rx_tickgen, the clearable TPS tick counter with a sync clear input.

Test Plan (CLOCK_SPEED=1600, BAUD_RATE=100, OVERSAMPLE=16, TPS=1, so a bit is 16 clk):
- Send 0xA5 (start 0, data LSB first, stop 1), rx_ready held 1 → rx_valid pulses 1 clk exactly 156 clk after the falling edge, rx_data = 0xA5, frame_err = 0.
- Low glitch on rx of 4 clk, then high → no rx_valid, FSM back in IDLE; following frame 0x3C received correctly.
- Frame 0x55 with stop bit driven 0, then line held low 400 clk → one frame_err pulse, rx_valid stays 0; after rx returns high, frame 0x81 is received.
- rx_ready = 0; send 0x11 then 0x22 → rx_data = 0x11, rx_valid = 1, overrun = 1; raise rx_ready 1 clk → rx_valid = 0 and overrun = 0 next clk.
- Accept handshake in the same clock as a DONE → new byte loaded, rx_valid stays 1, overrun = 0.
- reset pulsed low mid-DATA of 0xF0 → all outputs 0 asynchronously; next frame 0x0F received with correct latency. With UART_RX_PARITY_EN: 0x07 sent with parity bit 0 → parity_err pulses, rx_data = 0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver.
// The PARITY state is only reachable when UART_RX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5,
    BREAK  = 3'd6
  } rx_state_t;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DATA_BITS  = 8;

  function automatic int calc_tps(input int clock, input int baud, input int os);
    return clock / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_tickgen.sv
// Oversample tick generator: one-clk tick every TPS clocks, held at zero while clr is high.
module uart_rx_tickgen #(
  parameter int TPS = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TPS > 1) ? $clog2(TPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TPS - 1);

  logic [CW-1:0] cnt;

  // Combinational tick so the first one lands TPS clocks after clr drops.
  assign tick = !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            cnt <= '0;
    else if (clr || tick)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with a valid/ready holding register, framing and overrun flags.
// Define UART_RX_PARITY_EN to add an even-parity bit check and the parity_err port.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_SPEED = 9600 * 16,
  parameter int BAUD_RATE   = 9600,
  parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int TPS         = calc_tps(CLOCK_SPEED, BAUD_RATE, OVERSAMPLE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 overrun
);

  if (TPS < 1) begin : g_tps_chk
    $error("uart_rx: CLOCK_SPEED too low for BAUD_RATE*OVERSAMPLE (TPS < 1)");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
    $error("uart_rx: OVERSAMPLE must be even and >= 4");
  end

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 s1, rxs;
  logic [2:0]           state;
  logic [SW-1:0]        scnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] sh;
  logic                 tick;
`ifdef UART_RX_PARITY_EN
  logic                 pbit;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1  <= 1'b1;
      rxs <= 1'b1;
    end else begin
      s1  <= rx;
      rxs <= s1;
    end
  end

  uart_rx_tickgen #(.TPS(TPS)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (state == IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      scnt      <= '0;
      bcnt      <= '0;
      sh        <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbit       <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
      case (state)
        IDLE: if (!rxs) begin
          state <= START;
          scnt  <= '0;
        end
        // Re-check the start bit at its middle to reject short glitches.
        START: if (tick) begin
          if (scnt == S_HALF) begin
            scnt <= '0;
            bcnt <= '0;
            state <= rxs ? IDLE : DATA;
          end else scnt <= scnt + 1'b1;
        end
        DATA: if (tick) begin
          if (scnt == S_LAST) begin
            scnt <= '0;
            sh   <= {rxs, sh[DATA_BITS-1:1]};
            if (bcnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else bcnt <= bcnt + 1'b1;
          end else scnt <= scnt + 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick) begin
          if (scnt == S_LAST) begin
            scnt  <= '0;
            pbit  <= rxs;
            state <= STOP;
          end else scnt <= scnt + 1'b1;
        end
`endif
        STOP: if (tick) begin
          if (scnt == S_LAST) begin
            scnt <= '0;
            if (rxs) state <= DONE;
            else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else scnt <= scnt + 1'b1;
        end
        // A same-cycle accept frees the register, so the new byte is not an overrun.
        DONE: begin
          if (!rx_valid || rx_ready) begin
            rx_data  <= sh;
            rx_valid <= 1'b1;
          end else overrun <= 1'b1;
`ifdef UART_RX_PARITY_EN
          parity_err <= ^{sh, pbit};
`endif
          state <= IDLE;
        end
        BREAK: if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model plus directed and random frames.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam int PX = 16;
`else
  localparam int PX = 0;
`endif
  localparam int LAT = 156 + PX;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  always #5 clk = ~clk;

  uart_rx #(
    .CLOCK_SPEED(1600), .BAUD_RATE(100), .OVERSAMPLE(16), .DATA_BITS(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  typedef struct {
    int         at;
    logic [7:0] d;
    bit         ferr;
    bit         perr;
  } ev_t;

  ev_t        evq[$];
  int         cyc = 0;
  int         tests = 0, fails = 0;
  bit         abort = 1'b0;
  bit         rnd_on;
  logic       m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0, m_perr = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         last_t0 = 0, rise_cyc = -1, ferr_cnt = 0, perr_cnt = 0;
  logic [7:0] rise_data = 8'h00;
  logic       prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: each sent frame schedules its outcome at a fixed cycle; the holding register
  // follows the valid/ready load rule at frame level.
  task automatic model_loop();
    ev_t e;
    bit  hs, full;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_valid = 1'b0; m_ovr = 1'b0; m_data = 8'h00; m_ferr = 1'b0; m_perr = 1'b0;
        evq.delete();
      end else begin
        cyc++;
        full = m_valid;
        hs   = m_valid && rx_ready;
        m_ferr = 1'b0;
        m_perr = 1'b0;
        if (hs) begin
          m_valid = 1'b0;
          m_ovr   = 1'b0;
        end
        if (evq.size() > 0 && evq[0].at == cyc) begin
          e = evq.pop_front();
          if (e.ferr) m_ferr = 1'b1;
          else begin
            if (!full || hs) begin
              m_data  = e.d;
              m_valid = 1'b1;
            end else m_ovr = 1'b1;
            m_perr = e.perr;
          end
        end
      end
    end
  endtask

  task automatic compare_loop();
    logic pe;
    forever begin
      @(negedge clk);
`ifdef UART_RX_PARITY_EN
      pe = parity_err;
`else
      pe = 1'b0;
`endif
      if (!reset) prev_valid = 1'b0;
      else begin
        if (rx_valid && !prev_valid) begin
          rise_cyc  = cyc;
          rise_data = rx_data;
        end
        prev_valid = rx_valid;
        if (frame_err) ferr_cnt++;
        if (pe) perr_cnt++;
        check("cycle{valid,ovr,ferr,perr,data}",
              {20'd0, rx_valid, overrun, frame_err, pe, rx_data},
              {20'd0, m_valid, m_ovr, m_ferr, m_perr, m_data});
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input bit stop, input bit pbad, input int gap);
    logic bits[$];
    ev_t  e;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (PX != 0) bits.push_back(^d ^ pbad);
    bits.push_back(stop);
    @(posedge clk); #1;
    last_t0 = cyc;
    e.at   = stop ? cyc + LAT : cyc + LAT - 1;
    e.d    = d;
    e.ferr = !stop;
    e.perr = (PX != 0) && pbad;
    evq.push_back(e);
    foreach (bits[i]) begin
      rx = bits[i];
      for (int k = 0; k < 16; k++) begin
        @(posedge clk); #1;
        if (abort) begin
          rx = 1'b1;
          return;
        end
      end
    end
    rx = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  initial begin
    int fc, pc;
    fork
      model_loop();
      compare_loop();
    join_none

    #1;
    check("reset rx_data", {24'd0, rx_data}, 32'h0);
    check("reset rx_valid", {31'd0, rx_valid}, 32'h0);
    check("reset frame_err", {31'd0, frame_err}, 32'h0);
    check("reset overrun", {31'd0, overrun}, 32'h0);
    #12 reset = 1'b1;
    repeat (5) @(posedge clk);

    // Basic frame, consumer always ready
    rx_ready = 1'b1;
    send(8'hA5, 1'b1, 1'b0, 4);
    check("A5 latency", rise_cyc - last_t0, LAT);
    check("A5 data", {24'd0, rise_data}, 32'hA5);

    // Short low glitch must be rejected
    @(posedge clk); #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (20) @(posedge clk);
    send(8'h3C, 1'b1, 1'b0, 4);
    check("3C latency", rise_cyc - last_t0, LAT);
    check("3C data", {24'd0, rise_data}, 32'h3C);

    // Bad stop bit then break: exactly one frame_err
    fc = ferr_cnt;
    send(8'h55, 1'b0, 1'b0, 0);
    rx = 1'b0;
    repeat (400) @(posedge clk);
    #1 rx = 1'b1;
    repeat (10) @(posedge clk);
    check("break ferr pulses", ferr_cnt - fc, 1);
    @(negedge clk) check("break no valid", {31'd0, rx_valid}, 32'h0);
    send(8'h81, 1'b1, 1'b0, 4);
    check("81 data", {24'd0, rise_data}, 32'h81);

    // Overrun: two frames with consumer stalled
    rx_ready = 1'b0;
    send(8'h11, 1'b1, 1'b0, 2);
    send(8'h22, 1'b1, 1'b0, 4);
    @(negedge clk);
    check("ovr data", {24'd0, rx_data}, 32'h11);
    check("ovr valid", {31'd0, rx_valid}, 32'h1);
    check("ovr flag", {31'd0, overrun}, 32'h1);
    @(posedge clk); #1 rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
    @(negedge clk);
    check("accept clears valid", {31'd0, rx_valid}, 32'h0);
    check("accept clears ovr", {31'd0, overrun}, 32'h0);

    // Accept in the same clock as DONE, with overrun pending
    send(8'h33, 1'b1, 1'b0, 2);
    send(8'h3A, 1'b1, 1'b0, 2);
    fork
      send(8'h44, 1'b1, 1'b0, 4);
      begin
        @(posedge clk);
        repeat (LAT - 1) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
        @(negedge clk);
        check("same-cycle valid", {31'd0, rx_valid}, 32'h1);
        check("same-cycle data", {24'd0, rx_data}, 32'h44);
        check("same-cycle ovr", {31'd0, overrun}, 32'h0);
      end
    join
    @(posedge clk); #1 rx_ready = 1'b1;
    repeat (3) @(posedge clk);

    // Mid-frame asynchronous reset
    fork
      send(8'hF0, 1'b1, 1'b0, 1);
    join_none
    repeat (60) @(posedge clk);
    #3 reset = 1'b0;
    abort = 1'b1;
    #1;
    check("midrst valid", {31'd0, rx_valid}, 32'h0);
    check("midrst data", {24'd0, rx_data}, 32'h0);
    check("midrst ovr", {31'd0, overrun}, 32'h0);
    check("midrst ferr", {31'd0, frame_err}, 32'h0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    abort = 1'b0;
    repeat (20) @(posedge clk);
    send(8'h0F, 1'b1, 1'b0, 4);
    check("0F latency", rise_cyc - last_t0, LAT);
    check("0F data", {24'd0, rise_data}, 32'h0F);

`ifdef UART_RX_PARITY_EN
    pc = perr_cnt;
    send(8'h07, 1'b1, 1'b1, 4);
    check("parity err pulse", perr_cnt - pc, 1);
    check("parity data kept", {24'd0, rise_data}, 32'h07);
`else
    pc = perr_cnt;
`endif

    // Random frames with a randomly stalling consumer
    rnd_on = 1'b1;
    fork
      begin
        for (int n = 0; n < 24; n++) begin
          bit bad;
          bad = ($urandom_range(0, 5) == 0);
          send(8'($urandom), !bad, 1'($urandom_range(0, 1)),
               bad ? $urandom_range(3, 8) : $urandom_range(0, 6));
        end
        rnd_on = 1'b0;
      end
      while (rnd_on) begin
        @(posedge clk); #1 rx_ready = 1'($urandom_range(0, 1));
      end
    join
    rx_ready = 1'b1;
    repeat (20) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
